// File: rtl/mole_scheduler_pkg.sv
// Shared types and constants for the whack-a-mole spawn scheduler.
package mole_scheduler_pkg;

  localparam int unsigned NUM_MOLES = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned BCD_W     = 4;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PICK,
    ST_LAUNCH,
    ST_DONE
  } state_e;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [NUM_MOLES-1:0] mole_onehot(input logic [IDX_W-1:0] i);
    return NUM_MOLES'(1) << i;
  endfunction

endpackage

// File: rtl/mole_scheduler_bcd_down_counter2.sv
// Two-digit BCD down counter with load, enable and zero flag; shared by the
// game timer and the display/score stages.
module bcd_down_counter2
  import mole_scheduler_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] count,
  output logic       zero,
  output logic       last_c
);

  bcd_digit_t tens_q, tens_d;
  bcd_digit_t ones_q, ones_d;
  logic       zero_q, zero_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load) begin
      {tens_d, ones_d} = load_val;
    end else if (en) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
    zero_d = ({tens_d, ones_d} == 8'h00);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      {tens_q, ones_q} <= RESET_VAL;
      zero_q           <= (RESET_VAL == 8'h00);
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      zero_q <= zero_d;
    end
  end

  assign count  = {tens_q, ones_q};
  assign zero   = zero_q;
  // Next decrement lands on zero.
  assign last_c = ({tens_q, ones_q} == 8'h01);

endmodule

// File: rtl/mole_scheduler.sv
// Game-level spawn controller: runs the BCD game timer, picks a random hidden
// mole at random intervals and drives its go line plus a one-cycle rise pulse.
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SEC = 50_000_000,
  parameter logic [7:0]  GAME_SECONDS   = 8'h60,
  parameter int unsigned SPAWN_BASE     = 25_000_000,
  parameter int unsigned SPAWN_SHIFT    = 21,
  parameter int unsigned GO_TIMEOUT     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] hiding,
  output logic [NUM_MOLES-1:0] control,
  output logic [NUM_MOLES-1:0] rise,
  output logic [7:0]           time_left,
  output logic                 game_active,
  output logic                 game_over
);

  localparam int unsigned PRE_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam int unsigned GO_W  = $clog2(GO_TIMEOUT + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_SEC - 1);
  localparam logic [GO_W-1:0]  GO_LAST  = GO_W'(GO_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic [31:0]          wait_q, wait_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     tries_q, tries_d;
  logic [GO_W-1:0]      go_cnt_q, go_cnt_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [NUM_MOLES-1:0] control_q, control_d;
  logic [NUM_MOLES-1:0] rise_q, rise_d;
  logic                 active_q, active_d;
  logic                 over_q, over_d;

  logic [31:0] reload_val;
  logic        tick;
  logic        expire;
  logic        start_game;
  logic        tl_zero;
  logic        tl_last_c;

  assign reload_val = SPAWN_BASE + (32'(lfsr_q[3:0]) << SPAWN_SHIFT);
  assign tick       = active_q && (pre_q == PRE_LAST);
  // A 00 game still ends after its first second instead of wrapping to 99.
  assign expire     = tick && (tl_last_c || tl_zero);
  assign start_game = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;

  bcd_down_counter2 #(
    .RESET_VAL(GAME_SECONDS)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (start_game),
    .load_val(GAME_SECONDS),
    .en      (tick && !tl_zero),
    .count   (time_left),
    .zero    (tl_zero),
    .last_c  (tl_last_c)
  );

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_step(lfsr_q);
    wait_d   = wait_q;
    idx_d    = idx_q;
    tries_d  = tries_q;
    go_cnt_d = go_cnt_q;
    pre_d    = pre_q;
    over_d   = over_q;

    if (active_q) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT;
          wait_d  = reload_val;
          pre_d   = '0;
          over_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wait_q <= 32'd1) begin
          wait_d  = '0;
          idx_d   = lfsr_q[IDX_W-1:0];
          tries_d = '0;
          state_d = ST_PICK;
        end else begin
          wait_d = wait_q - 32'd1;
        end
      end
      ST_PICK: begin
        if (hiding[idx_q]) begin
          state_d  = ST_LAUNCH;
          go_cnt_d = '0;
        end else if (tries_q == IDX_W'(NUM_MOLES - 1)) begin
          state_d = ST_WAIT;
          wait_d  = reload_val;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          tries_d = tries_q + IDX_W'(1);
        end
      end
      ST_LAUNCH: begin
        if (!hiding[idx_q] || (go_cnt_q == GO_LAST)) begin
          state_d = ST_WAIT;
          wait_d  = reload_val;
        end else begin
          go_cnt_d = go_cnt_q + GO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timer expiry overrides any spawn activity in the same cycle.
    if (expire) begin
      state_d = ST_DONE;
      over_d  = 1'b1;
    end

    active_d  = (state_d == ST_WAIT) || (state_d == ST_PICK) || (state_d == ST_LAUNCH);
    control_d = (state_d == ST_LAUNCH) ? mole_onehot(idx_d) : '0;
    rise_d    = ((state_d == ST_LAUNCH) && (state_q != ST_LAUNCH)) ? mole_onehot(idx_d) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      wait_q    <= '0;
      idx_q     <= '0;
      tries_q   <= '0;
      go_cnt_q  <= '0;
      pre_q     <= '0;
      control_q <= '0;
      rise_q    <= '0;
      active_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      tries_q   <= tries_d;
      go_cnt_q  <= go_cnt_d;
      pre_q     <= pre_d;
      control_q <= control_d;
      rise_q    <= rise_d;
      active_q  <= active_d;
      over_q    <= over_d;
    end
  end

  assign control     = control_q;
  assign rise        = rise_q;
  assign game_active = active_q;
  assign game_over   = over_q;

endmodule
